piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts the MSB out first, 0 shifts the LSB out first.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port clk_inh, input, 1: when high, all state (shift register, counter, FSM, done) is frozen.
REQ-006 Port load_valid, input, 1: a parallel word is offered on data_in.
REQ-007 Port load_ready, output, 1: block accepts a word this cycle; a word is taken when load_valid && load_ready at a rising edge.
REQ-008 Port data_in, input, WIDTH: parallel word.
REQ-009 Port shift_in, input, 1: fill bit entering the vacated end on each shift (cascade input).
REQ-010 Port q, output, 1: current serial bit.
REQ-011 Port q_n, output, 1: always ~q.
REQ-012 Port busy, output, 1: FSM is in SHIFT.
REQ-013 Port last_bit, output, 1: q carries the final bit of the current word.
REQ-014 Port done, output, 1: registered one-cycle pulse after a word has completed.

Function
REQ-015 FSM states: IDLE and SHIFT; the reset state is IDLE.
REQ-016 load_ready = !clk_inh && (state==IDLE || (state==SHIFT && count==0)); combinational.
REQ-017 On an accepted word: shift register <= data_in, count <= WIDTH-1, state <= SHIFT.
REQ-018 q = sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0]; the first bit appears on the cycle after acceptance.
REQ-019 In SHIFT with count!=0 and !clk_inh: shift one position toward the output end, insert shift_in at the opposite end, count <= count-1.
REQ-020 Each bit is held on q for exactly one non-inhibited cycle; a word takes WIDTH non-inhibited cycles.
REQ-021 last_bit = (state==SHIFT && count==0); combinational.
REQ-022 In SHIFT with count==0 and !clk_inh: done <= 1 for one cycle. With load_valid high, the next word loads at that same edge (back-to-back, no gap bit); otherwise state <= IDLE.
REQ-023 In IDLE the shift register holds its value; q shows its output bit; no shifting occurs.
REQ-024 clk_inh high freezes q, count, state and the register; done is cleared to 0; load_ready=0.
REQ-025 load_valid while busy with count!=0 is ignored; the word is not captured.
REQ-026 The counter is $clog2(WIDTH) bits wide and never wraps below 0.

Reset
REQ-027 rst high clears immediately and asynchronously: sreg=0, count=0, state=IDLE, done=0; therefore q=0, q_n=1, busy=0, last_bit=0.
REQ-028 rst asserted mid-word aborts the word; no done pulse is produced for it.
REQ-029 After rst deasserts, the first rising edge may accept a word.

Structure
REQ-030 Package piso_pkg holds the state enum (IDLE, SHIFT) and the counter-width localparam function.
REQ-031 One sub-module, piso_shift_core, holds the WIDTH-bit register with load/shift/hold controls and the MSB_FIRST direction select; the FSM and counter stay in piso_serializer.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, load 0xA5, shift_in=0: q sequence 1,0,1,0,0,1,0,1; last_bit on the 8th bit; done one cycle later; busy low after.
REQ-033 MSB_FIRST=0, load 0x01: q sequence 1,0,0,0,0,0,0,0.
REQ-034 Back-to-back: load 0xFF, then hold load_valid with 0x00 ready at the last bit: 16 contiguous bits 8x1 then 8x0, no gap; done pulses twice.
REQ-035 clk_inh high for 3 cycles after bit 2 of 0xC3: q frozen on bit 2 value; the sequence resumes intact; total 11 cycles.
REQ-036 rst pulse mid-word (after bit 4): q=0, q_n=1, busy=0 immediately; no done pulse; the next load of 0x81 serializes correctly.
REQ-037 Cascade: WIDTH=4, load 0x0, shift_in driven 1: q shows 0,0,0,0; the register afterwards holds 0xF.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the PISO serializer.
//   state_e    - FSM state encoding (IDLE, SHIFT)
//   cnt_width  - width of the bit counter for a given word width
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake, control and serial output bundle.
//   master: drives clk_inh, load_valid, data_in, shift_in; observes outputs
//   slave : the serializer; drives load_ready, q, q_n, busy, last_bit, done
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic             clk_inh;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             shift_in;
  logic             q;
  logic             q_n;
  logic             busy;
  logic             last_bit;
  logic             done;

  modport master (
    output clk_inh, load_valid, data_in, shift_in,
    input  load_ready, q, q_n, busy, last_bit, done
  );

  modport slave (
    input  clk_inh, load_valid, data_in, shift_in,
    output load_ready, q, q_n, busy, last_bit, done
  );

endinterface

// File: rtl/piso_shift_core.sv
// piso_shift_core: WIDTH-bit shift register with load / shift / hold.
//   clk, rst  - clock, asynchronous active-high reset (clears register)
//   load      - capture data_in (has priority over shift)
//   shift     - move one place toward the output end, shift_in fills in
//   q         - output-end bit (MSB when MSB_FIRST, else LSB)
module piso_shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_in,
  output logic             q
);

  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] shifted_s;

  // Direction select: the output end and the fill end are opposite.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted_s = {sreg_r[WIDTH-2:0], shift_in};
      assign q         = sreg_r[WIDTH-1];
    end else begin : g_lsb
      assign shifted_s = {shift_in, sreg_r[WIDTH-1:1]};
      assign q         = sreg_r[0];
    end
  endgenerate

  // Shift register: load, shift or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sreg_r <= data_in;
    end else if (shift) begin
      sreg_r <= shifted_s;
    end else begin
      sreg_r <= sreg_r;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out converter with valid/ready load.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - piso_serializer_if slave: clk_inh freezes everything,
//              load_valid/load_ready/data_in load a word, shift_in is the
//              cascade fill bit, q/q_n serial out, busy, last_bit, done
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  piso_serializer_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(32'd1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(32'd0);

  state_e        state_r;
  state_e        next_state_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] next_count_s;
  logic          done_r;
  logic          next_done_s;
  logic          load_s;
  logic          shift_s;
  logic          ready_s;
  logic          accept_s;
  logic          count_zero_s;
  logic          q_s;

  assign count_zero_s = (count_r == ZERO_CNT);
  assign ready_s      = !bus.clk_inh &&
                        ((state_r == IDLE) || ((state_r == SHIFT) && count_zero_s));
  assign accept_s     = bus.load_valid && ready_s;

  // Next-state, counter and shift-core controls.
  always_comb begin
    next_state_s = state_r;
    next_count_s = count_r;
    next_done_s  = 1'b0;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    if (bus.clk_inh) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            load_s       = 1'b1;
            next_count_s = LAST_CNT;
            next_state_s = SHIFT;
          end else begin
            next_state_s = IDLE;
          end
        end
        SHIFT: begin
          if (!count_zero_s) begin
            shift_s      = 1'b1;
            next_count_s = count_r - ONE_CNT;
          end else begin
            next_done_s = 1'b1;
            if (accept_s) begin
              load_s       = 1'b1;
              next_count_s = LAST_CNT;
              next_state_s = SHIFT;
            end else begin
              // Final bit leaves too, so the register ends up holding the
              // WIDTH cascade bits that followed the word.
              shift_s      = 1'b1;
              next_state_s = IDLE;
            end
          end
        end
        default: begin
          next_state_s = IDLE;
          next_count_s = ZERO_CNT;
        end
      endcase
    end
  end

  // FSM, counter and done pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= ZERO_CNT;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      count_r <= next_count_s;
      done_r  <= next_done_s;
    end
  end

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .shift    (shift_s),
    .data_in  (bus.data_in),
    .shift_in (bus.shift_in),
    .q        (q_s)
  );

  assign bus.load_ready = ready_s;
  assign bus.q          = q_s;
  assign bus.q_n        = ~q_s;
  assign bus.busy       = (state_r == SHIFT);
  assign bus.last_bit   = (state_r == SHIFT) && count_zero_s;
  assign bus.done       = done_r;

endmodule
